// File: rtl/data_ram_resp.sv
// -----------------------------------------------------------------------------
// data_ram_resp
//
// Data-memory responder at the far end of the MEM-stage memory interface.
// The MEM stage raises a single load or store request and holds it. This block
// accepts the request, waits WAIT_CYCLES extra cycles, and then performs the
// byte-enabled write or the full-word read on an internal 2^ADDR_W x 32 array.
// Completion is a one-cycle mem_ready_o pulse that carries the read data or
// an error flag.
//
// Optional build feature (off by default):
//   DATA_RAM_ALIGN_CHECK_EN - reject byte-lane patterns that do not match a
//                             legal big-endian byte/half/word access for
//                             addr[1:0]. The rejected access still completes,
//                             with mem_err_o=1 and no write.
//
// Parameters:
//   ADDR_W       word-address bits; array depth is 2^ADDR_W words
//   WAIT_CYCLES  extra wait cycles between acceptance and completion (0..15)
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   mem_ce_i     request valid, held by the initiator until mem_ready_o
//   mem_we_i     1 = store, 0 = load
//   mem_addr_i   byte address
//   mem_sel_i    byte-lane enables (bit3 = data[31:24], bit0 = data[7:0])
//   mem_data_i   store data
//   mem_ready_o  completion pulse, exactly one cycle per accepted request
//   mem_data_o   load data, valid only with mem_ready_o, otherwise 0
//   mem_err_o    error flag, only high together with mem_ready_o
//   busy_o       high whenever the responder is not idle
// -----------------------------------------------------------------------------
module data_ram_resp #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic        mem_ready_o,
  output logic [31:0] mem_data_o,
  output logic        mem_err_o,
  output logic        busy_o
);

  localparam int DEPTH   = 1 << ADDR_W;
  localparam bit NO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t      state;
  logic [3:0]  cnt;

  // Request captured at the accepting edge; inputs are ignored afterwards.
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_sel;
  logic [31:0] req_data;

  logic [31:0] mem [DEPTH];

  // Operands of the access performed on the edge entering RESP. With no wait
  // states that edge is the accepting edge itself, so the live inputs are used
  // in IDLE; otherwise the captured copy is used.
  logic              op_we;
  logic [31:0]       op_addr;
  logic [3:0]        op_sel;
  logic [31:0]       op_data;
  logic [ADDR_W-1:0] op_idx;
  logic              op_oor;
  logic              op_align_ok;
  logic              enter_resp;
  logic              resp_err;
  logic [31:0]       resp_data;
  logic              write_ok;
  logic              do_write;

  // NOTE: every signal driven here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    op_we   = req_we;
    op_addr = req_addr;
    op_sel  = req_sel;
    op_data = req_data;
    if (state == ST_IDLE) begin
      op_we   = mem_we_i;
      op_addr = mem_addr_i;
      op_sel  = mem_sel_i;
      op_data = mem_data_i;
    end
  end

  assign op_idx = op_addr[ADDR_W+1:2];
  assign op_oor = (op_addr[31:ADDR_W+2] != '0);

`ifdef DATA_RAM_ALIGN_CHECK_EN
  // Legal big-endian lane patterns: lane 3 holds the byte at offset 0.
  function automatic logic align_legal(input logic we, input logic [1:0] lo,
                                       input logic [3:0] sel);
    logic ok;
    ok = 1'b0;
    case (sel)
      4'b1111, 4'b1100, 4'b1000: ok = (lo == 2'b00);
      4'b0011, 4'b0010:          ok = (lo == 2'b10);
      4'b0100:                   ok = (lo == 2'b01);
      4'b0001:                   ok = (lo == 2'b11);
      4'b0000:                   ok = we;  // empty store is a legal no-op
      default:                   ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign op_align_ok = align_legal(op_we, op_addr[1:0], op_sel);
`else
  // Without the check the two byte-offset bits carry no meaning.
  logic unused_addr_lo;
  assign unused_addr_lo = ^op_addr[1:0];
  assign op_align_ok    = 1'b1;
`endif

  assign enter_resp = (NO_WAIT && (state == ST_IDLE) && mem_ce_i) ||
                      ((state == ST_WAIT) && (cnt == 4'd0));

  assign resp_err  = op_oor || !op_align_ok;
  // sel is deliberately ignored on loads; lane extraction is the MEM stage's job.
  assign resp_data = (op_we || resp_err) ? 32'h0 : mem[op_idx];

  // With no wait states the write edge is an IDLE edge, which reset must block;
  // otherwise reset already pins the state away from the write condition.
  generate
    if (NO_WAIT) begin : g_write_gate
      assign write_ok = rst;
    end else begin : g_no_write_gate
      assign write_ok = 1'b1;
    end
  endgenerate

  assign do_write = enter_resp && op_we && !resp_err && write_ok;

  // NOTE: the array has no reset; clearing it would turn a RAM into a flop
  // bank, and its contents are undefined after reset anyway.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (op_sel[b]) begin
          mem[op_idx][8*b +: 8] <= op_data[8*b +: 8];
        end
      end
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // updates from pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      cnt         <= 4'd0;
      req_we      <= 1'b0;
      req_addr    <= 32'h0;
      req_sel     <= 4'h0;
      req_data    <= 32'h0;
      mem_ready_o <= 1'b0;
      mem_data_o  <= 32'h0;
      mem_err_o   <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mem_ce_i) begin
            req_we   <= mem_we_i;
            req_addr <= mem_addr_i;
            req_sel  <= mem_sel_i;
            req_data <= mem_data_i;
            busy_o   <= 1'b1;
            if (NO_WAIT) begin
              state       <= ST_RESP;
              mem_ready_o <= 1'b1;
              mem_data_o  <= resp_data;
              mem_err_o   <= resp_err;
            end else begin
              state <= ST_WAIT;
              cnt   <= 4'(WAIT_CYCLES - 1);
            end
          end
        end

        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state       <= ST_RESP;
            mem_ready_o <= 1'b1;
            mem_data_o  <= resp_data;
            mem_err_o   <= resp_err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        ST_RESP: begin
          // ce is not sampled here, giving the initiator a cycle to drop it.
          state       <= ST_IDLE;
          mem_ready_o <= 1'b0;
          mem_data_o  <= 32'h0;
          mem_err_o   <= 1'b0;
          busy_o      <= 1'b0;
        end

        default: begin
          state       <= ST_IDLE;
          mem_ready_o <= 1'b0;
          mem_data_o  <= 32'h0;
          mem_err_o   <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_ram_resp.sv
// -----------------------------------------------------------------------------
// tb_data_ram_resp
//
// Self-checking bench for data_ram_resp (ADDR_W=10, WAIT_CYCLES=2). Directed
// scenarios cover reset, word and byte-lane stores, out-of-range accesses,
// held request valid and reset in the middle of a request; a randomized phase
// compares against a word-array reference model. Build with
// DATA_RAM_ALIGN_CHECK_EN defined to also exercise the alignment check.
// -----------------------------------------------------------------------------
module tb_data_ram_resp;

  localparam int ADDR_W      = 10;
  localparam int WAIT_CYCLES = 2;
  localparam int LATENCY     = WAIT_CYCLES + 1;  // falling edges after E0
  localparam int BUDGET      = 40;
  localparam int WIN         = 16;                // words used by random phase

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ce;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_sel;
  logic [31:0] mem_wdata;
  logic        mem_ready_o;
  logic [31:0] mem_data_o;
  logic        mem_err_o;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] model [WIN];

  data_ram_resp #(
    .ADDR_W     (ADDR_W),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_ce_i   (mem_ce),
    .mem_we_i   (mem_we),
    .mem_addr_i (mem_addr),
    .mem_sel_i  (mem_sel),
    .mem_data_i (mem_wdata),
    .mem_ready_o(mem_ready_o),
    .mem_data_o (mem_data_o),
    .mem_err_o  (mem_err_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Legality of a lane pattern computed from access size and byte offset:
  // a size-s access at offset o (o multiple of s) covers lanes 3-o .. 4-o-s.
  function automatic logic ref_legal(input logic we, input logic [31:0] addr,
                                     input logic [3:0] sel);
`ifdef DATA_RAM_ALIGN_CHECK_EN
    int o;
    o = int'(addr[1:0]);
    if (sel == 4'b0000) return we;
    for (int s = 1; s <= 4; s = s * 2) begin
      if ((o % s) == 0 && (o + s) <= 4) begin
        if (int'(sel) == (((1 << s) - 1) << (4 - o - s))) return 1'b1;
      end
    end
    return 1'b0;
`else
    return (we || !we) && (addr == addr) && (sel == sel);
`endif
  endfunction

  // Drives one request from a falling edge with the DUT idle, holds ce until
  // the ready pulse, scrambles the other inputs after acceptance and returns
  // what the pulse carried plus its latency in falling edges after E0.
  task automatic do_req(input logic we, input logic [31:0] addr,
                        input logic [3:0] sel, input logic [31:0] data,
                        output logic [31:0] rdata, output logic rerr,
                        output int lat);
    mem_ce    = 1'b1;
    mem_we    = we;
    mem_addr  = addr;
    mem_sel   = sel;
    mem_wdata = data;
    lat   = -1;
    rdata = 32'h0;
    rerr  = 1'b0;
    for (int k = 1; k <= BUDGET; k++) begin
      @(negedge clk);
      mem_we    = 1'($urandom);
      mem_addr  = $urandom;
      mem_sel   = 4'($urandom);
      mem_wdata = $urandom;
      checks++;
      if (busy_o !== 1'b1) begin
        errors++;
        $display("FAIL busy_during_req: busy_o=%b required 1 (edge %0d)", busy_o, k);
      end
      if (mem_ready_o === 1'b1) begin
        lat   = k;
        rdata = mem_data_o;
        rerr  = mem_err_o;
        break;
      end
      checks++;
      if ({mem_data_o, mem_err_o} !== 33'h0) begin
        errors++;
        $display("FAIL quiet_outputs: data=%h err=%b required 0 while not ready",
                 mem_data_o, mem_err_o);
      end
    end
    mem_ce = 1'b0;
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: no ready within %0d cycles", BUDGET);
    end
    @(negedge clk);
    checks++;
    if ({mem_ready_o, busy_o, mem_err_o, mem_data_o} !== 35'h0) begin
      errors++;
      $display("FAIL pulse_end: ready=%b busy=%b err=%b data=%h required all 0",
               mem_ready_o, busy_o, mem_err_o, mem_data_o);
    end
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    logic        re;
    int          lat;
    rst = 1'b0;
    mem_ce = 1'b0; mem_we = 1'b0; mem_addr = 32'h0; mem_sel = 4'h0; mem_wdata = 32'h0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_ready_o, busy_o, mem_err_o, mem_data_o} !== 35'h0) begin
      errors++;
      $display("FAIL reset_state: ready=%b busy=%b err=%b data=%h required all 0",
               mem_ready_o, busy_o, mem_err_o, mem_data_o);
    end
    // Release with ce high at once: the first clean edge must accept.
    rst = 1'b1;
    do_req(1'b1, 32'h0, 4'hF, 32'h0BAD_F00D, rd, re, lat);
    checks++;
    if (lat != LATENCY) begin
      errors++;
      $display("FAIL reset_release_latency: got %0d required %0d", lat, LATENCY);
    end
    checks++;
    if (re !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_err: got %b required 0", re);
    end
    // Asynchronous assertion while busy, between edges.
    mem_ce = 1'b1; mem_we = 1'b0; mem_addr = 32'h0; mem_sel = 4'hF;
    @(posedge clk);
    #2;
    rst    = 1'b0;
    mem_ce = 1'b0;
    #1;
    checks++;
    if ({mem_ready_o, busy_o, mem_err_o, mem_data_o} !== 35'h0) begin
      errors++;
      $display("FAIL async_reset: ready=%b busy=%b err=%b data=%h required all 0",
               mem_ready_o, busy_o, mem_err_o, mem_data_o);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word_store_load;
    logic [31:0] rd;
    logic        re;
    int          lat;
    do_req(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, rd, re, lat);
    checks++;
    if (lat != LATENCY || re !== 1'b0 || rd !== 32'h0) begin
      errors++;
      $display("FAIL word_store: lat=%0d err=%b data=%h required lat=%0d err=0 data=0",
               lat, re, rd, LATENCY);
    end
    do_req(1'b0, 32'h10, 4'hF, 32'h0, rd, re, lat);
    checks++;
    if (lat != LATENCY || re !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL word_load: lat=%0d err=%b data=%h required lat=%0d err=0 data=deadbeef",
               lat, re, rd, LATENCY);
    end
  endtask

  task automatic test_byte_lane;
    logic [31:0] rd;
    logic        re;
    int          lat;
    do_req(1'b1, 32'h11, 4'b0100, 32'h0055_0000, rd, re, lat);
    checks++;
    if (re !== 1'b0) begin
      errors++;
      $display("FAIL byte_store_err: got %b required 0", re);
    end
    do_req(1'b0, 32'h10, 4'hF, 32'h0, rd, re, lat);
    checks++;
    if (rd !== 32'hDE55_BEEF || re !== 1'b0) begin
      errors++;
      $display("FAIL byte_lane_merge: data=%h err=%b required de55beef err=0", rd, re);
    end
    // An empty store completes normally and changes nothing.
    do_req(1'b1, 32'h10, 4'b0000, 32'hFFFF_FFFF, rd, re, lat);
    checks++;
    if (re !== 1'b0 || lat != LATENCY) begin
      errors++;
      $display("FAIL sel_zero_store: err=%b lat=%0d required err=0 lat=%0d", re, lat, LATENCY);
    end
    do_req(1'b0, 32'h10, 4'hF, 32'h0, rd, re, lat);
    checks++;
    if (rd !== 32'hDE55_BEEF) begin
      errors++;
      $display("FAIL sel_zero_unchanged: data=%h required de55beef", rd);
    end
  endtask

  task automatic test_out_of_range;
    logic [31:0] rd;
    logic        re;
    int          lat;
    logic [31:0] oor_addr [2];
    oor_addr[0] = 32'h0000_1000;
    oor_addr[1] = 32'h8000_0000;
    foreach (oor_addr[i]) begin
      do_req(1'b1, oor_addr[i], 4'hF, 32'h1234_5678, rd, re, lat);
      checks++;
      if (re !== 1'b1 || rd !== 32'h0 || lat != LATENCY) begin
        errors++;
        $display("FAIL oor_store %h: err=%b data=%h lat=%0d required err=1 data=0 lat=%0d",
                 oor_addr[i], re, rd, lat, LATENCY);
      end
      do_req(1'b0, oor_addr[i], 4'hF, 32'h0, rd, re, lat);
      checks++;
      if (re !== 1'b1 || rd !== 32'h0 || lat != LATENCY) begin
        errors++;
        $display("FAIL oor_load %h: err=%b data=%h lat=%0d required err=1 data=0 lat=%0d",
                 oor_addr[i], re, rd, lat, LATENCY);
      end
    end
    do_req(1'b0, 32'h0, 4'hF, 32'h0, rd, re, lat);
    checks++;
    if (rd !== 32'h0BAD_F00D || re !== 1'b0) begin
      errors++;
      $display("FAIL oor_no_alias: word0=%h err=%b required 0badf00d err=0", rd, re);
    end
  endtask

  task automatic test_held_ce;
    int pulses = 0;
    int first  = 0;
    int second = 0;
    mem_ce = 1'b1; mem_we = 1'b0; mem_addr = 32'h10; mem_sel = 4'hF; mem_wdata = 32'h0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (mem_ready_o === 1'b1) begin
        pulses++;
        if (pulses == 1) first = k;
        if (pulses == 2) begin
          second = k;
          mem_ce = 1'b0;
        end
        checks++;
        if (mem_data_o !== 32'hDE55_BEEF) begin
          errors++;
          $display("FAIL held_ce_data: data=%h required de55beef", mem_data_o);
        end
      end
    end
    mem_ce = 1'b0;
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL held_ce_pulses: got %0d required 2", pulses);
    end
    checks++;
    if (first != LATENCY || second - first != WAIT_CYCLES + 2) begin
      errors++;
      $display("FAIL held_ce_spacing: first=%0d spacing=%0d required %0d and %0d",
               first, second - first, LATENCY, WAIT_CYCLES + 2);
    end
    for (int k = 0; k < BUDGET && busy_o !== 1'b0; k++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op;
    logic [31:0] rd;
    logic        re;
    int          lat;
    int          seen;
    do_req(1'b1, 32'h8, 4'hF, 32'h1111_1111, rd, re, lat);
    // Reset during WAIT abandons the store.
    mem_ce = 1'b1; mem_we = 1'b1; mem_addr = 32'h8; mem_sel = 4'hF; mem_wdata = 32'h2222_2222;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_op_busy: busy_o=%b required 1", busy_o);
    end
    rst = 1'b0;
    mem_ce = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_req(1'b0, 32'h8, 4'hF, 32'h0, rd, re, lat);
    checks++;
    if (rd !== 32'h1111_1111) begin
      errors++;
      $display("FAIL reset_in_wait_abandon: data=%h required 11111111", rd);
    end
    // Reset during RESP: the store was committed on the edge entering RESP.
    mem_ce = 1'b1; mem_we = 1'b1; mem_addr = 32'h8; mem_sel = 4'hF; mem_wdata = 32'h3333_3333;
    seen = 0;
    for (int k = 1; k <= BUDGET; k++) begin
      @(negedge clk);
      if (mem_ready_o === 1'b1) begin
        seen = k;
        break;
      end
    end
    rst = 1'b0;
    mem_ce = 1'b0;
    #1;
    checks++;
    if (seen != LATENCY || mem_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_resp: latency=%0d ready=%b required %0d and 0",
               seen, mem_ready_o, LATENCY);
    end
    @(negedge clk);
    rst = 1'b1;
    do_req(1'b0, 32'h8, 4'hF, 32'h0, rd, re, lat);
    checks++;
    if (rd !== 32'h3333_3333) begin
      errors++;
      $display("FAIL reset_in_resp_commit: data=%h required 33333333", rd);
    end
  endtask

`ifdef DATA_RAM_ALIGN_CHECK_EN
  task automatic test_align;
    logic [31:0] rd;
    logic        re;
    int          lat;
    do_req(1'b0, 32'h12, 4'b1100, 32'h0, rd, re, lat);
    checks++;
    if (re !== 1'b1 || rd !== 32'h0 || lat != LATENCY) begin
      errors++;
      $display("FAIL align_bad_load: err=%b data=%h lat=%0d required err=1 data=0", re, rd, lat);
    end
    do_req(1'b1, 32'h12, 4'b0011, 32'h0000_1234, rd, re, lat);
    checks++;
    if (re !== 1'b0) begin
      errors++;
      $display("FAIL align_half_store: err=%b required 0", re);
    end
    do_req(1'b1, 32'h11, 4'hF, 32'h0, rd, re, lat);
    checks++;
    if (re !== 1'b1) begin
      errors++;
      $display("FAIL align_bad_store: err=%b required 1", re);
    end
    do_req(1'b0, 32'h10, 4'hF, 32'h0, rd, re, lat);
    checks++;
    if (rd !== 32'hDE55_1234 || re !== 1'b0) begin
      errors++;
      $display("FAIL align_result: data=%h err=%b required de551234 err=0", rd, re);
    end
  endtask
`endif

  task automatic test_random;
    logic [31:0] rd;
    logic        re;
    int          lat;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
    int          w;
    logic        exp_err;
    logic [31:0] exp_data;
    for (int i = 0; i < WIN; i++) begin
      model[i] = $urandom;
      do_req(1'b1, 32'(i * 4), 4'hF, model[i], rd, re, lat);
      checks++;
      if (re !== 1'b0 || lat != LATENCY) begin
        errors++;
        $display("FAIL rand_init %0d: err=%b lat=%0d required err=0 lat=%0d", i, re, lat, LATENCY);
      end
    end
    for (int n = 0; n < 60; n++) begin
      we   = 1'($urandom_range(0, 1));
      w    = int'($urandom_range(0, WIN - 1));
      sel  = 4'($urandom);
      data = $urandom;
      addr = 32'(w * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) addr = addr | ($urandom_range(1, 1048575) << 12);
      exp_err  = (addr >= 32'(4 << ADDR_W)) || !ref_legal(we, addr, sel);
      exp_data = (!exp_err && !we) ? model[w] : 32'h0;
      if (!exp_err && we) begin
        for (int b = 0; b < 4; b++) begin
          if (sel[b]) model[w][8*b +: 8] = data[8*b +: 8];
        end
      end
      do_req(we, addr, sel, data, rd, re, lat);
      checks++;
      if (re !== exp_err || rd !== exp_data || lat != LATENCY) begin
        errors++;
        $display("FAIL rand_op %0d (we=%b addr=%h sel=%b): err=%b data=%h lat=%0d required err=%b data=%h lat=%0d",
                 n, we, addr, sel, re, rd, lat, exp_err, exp_data, LATENCY);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_byte_lane();
    test_out_of_range();
    test_held_ce();
`ifdef DATA_RAM_ALIGN_CHECK_EN
    test_align();
`endif
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
